riscv_de_skidreg: RTL and testbench
===================================

Name: riscv_de_skidreg

Overview:
Parametrised successor to the fixed decode/execute pipeline register. It keeps the same stage boundary but replaces the stall enable with a valid/ready handshake and a 2-entry skid buffer, so backpressure from execute (multi-cycle mul/div, cache miss) does not create a combinational ready path back into decode. The payload is split into a control field, which is zeroed on flush or bubble, and a data field, which is kept unless configured otherwise. A saturating counter records backpressure cycles for performance analysis.

Parameters:
CTRL_W, 32, width of control payload (regwrite, memwrite, jump, alucontrol, ...); zeroed on flush/bubble
DATA_W, 416, width of data payload (pc, pcplus4, rs1/rs2 data, imm, addresses, opcode)
CLR_DATA, 0, 1 = data field also zeroed on flush; 0 = data held
CNT_W, 32, width of stall-cycle counter

Ports:
i_riscv_de_clk  in  1  clock, rising edge
i_riscv_de_rst  in  1  asynchronous reset, active-high
i_riscv_de_flush  in  1  synchronous flush; drops both entries and the incoming beat
i_riscv_de_valid_d  in  1  decode presents a beat
o_riscv_de_ready_d  out  1  stage can accept; equals (state != TWO), driven from state only
i_riscv_de_ctrl_d  in  CTRL_W  control payload
i_riscv_de_data_d  in  DATA_W  data payload
o_riscv_de_valid_e  out  1  main entry valid toward execute
i_riscv_de_ready_e  in  1  execute accepts this cycle
o_riscv_de_ctrl_e  out  CTRL_W  main-entry control
o_riscv_de_data_e  out  DATA_W  main-entry data
o_riscv_de_occ  out  2  occupancy 0/1/2
o_riscv_de_stallcnt  out  CNT_W  saturating backpressure-cycle count

Behaviour:
- Reset is asynchronous and active-high on i_riscv_de_rst, clocked by i_riscv_de_clk. On reset: state=EMPTY, valid_e=0, ctrl_e=0, data_e=0, skid regs=0, occ=0, stallcnt=0, ready_d=1.
- Definitions: in_fire = valid_d & ready_d; out_fire = valid_e & ready_e.
- Storage: main register (drives outputs directly, with no combinational path from inputs) and skid register.
- States: EMPTY (occ 0), ONE (main full, occ 1), TWO (main+skid full, occ 2).
- EMPTY: in_fire -> ONE, main<=in. Otherwise stay.
- ONE:
  - in_fire & out_fire -> ONE, main<=in.
  - in_fire & !out_fire -> TWO, skid<=in.
  - !in_fire & out_fire -> EMPTY.
  - Neither -> hold.
- TWO: ready_d=0, so no in_fire is possible. out_fire -> ONE, main<=skid. Otherwise hold.
- Latency: 1 cycle from in_fire into an empty stage to valid_e. Throughput is 1 beat/cycle with ready_e held high.
- Ordering is strictly FIFO; no beat is duplicated or lost except by flush.
- Bubble rule: whenever main becomes invalid (transition to EMPTY), main ctrl<=0. Data is held, or zeroed if CLR_DATA=1. Skid ctrl is likewise zeroed when skid empties.
- Flush (priority below reset, above all else):
  - Next state=EMPTY, valid_e=0.
  - Main and skid ctrl<=0; data per CLR_DATA.
  - A beat offered in the flush cycle is dropped even if ready_d=1.
  - out_fire in the flush cycle still counts as consumed downstream.
- Stall counter: increments each cycle with valid_e & !ready_e. It saturates at 2^CNT_W-1, is cleared only by reset, and is unaffected by flush.
- ctrl_e/data_e are stable while valid_e & !ready_e (required by the handshake).
- Reset mid-transfer: all beats lost, outputs zero immediately (asynchronous).

Decomposition:
- Shared package riscv_pipe_pkg:
  - typedef enum logic[1:0] {EMPTY, ONE, TWO} pipe_state_t
  - default widths DE_CTRL_W and DE_DATA_W
  - packed struct de_ctrl_t (regwrite, memwrite, jump, resultsrc, memext, alucontrol, mulctrl, divctrl, funcsel, storesrc, oprnd1sel, oprnd2sel, b_condition) so the top level packs and unpacks it consistently
- One sub-module: riscv_sat_cnt (parametrised CNT_W, inc enable, async reset), reused by later stages.

Test Plan:
1. Reset asserted mid-run with occ=2 -> same cycle valid_e=0, ctrl_e=0, data_e=0, occ=0, ready_d=1, stallcnt=0.
2. Stream beats ctrl=1..8 with ready_e=1 -> valid_e rises 1 cycle after the first in_fire; ctrl_e=1..8 on consecutive cycles; occ stays 1; stallcnt=0.
3. ready_e=0 while sending ctrl=0x11, 0x22, 0x33:
   - 0x11 goes to main, 0x22 to skid; ready_d=0; 0x33 is held by decode.
   - Release ready_e: outputs 0x11, 0x22, 0x33 in order.
   - stallcnt equals the number of valid_e & !ready_e cycles.
4. Flush with occ=2 while decode offers ctrl=0x44 -> next cycle occ=0, valid_e=0, ctrl_e=0; data_e holds (CLR_DATA=0) or is 0 (CLR_DATA=1); 0x44 never appears.
5. CNT_W=4, hold valid_e & !ready_e for 20 cycles -> stallcnt stops at 15.
6. Drain to EMPTY after beat ctrl=0xFF -> ctrl_e=0 the following cycle while data_e keeps the last data value (CLR_DATA=0).

Source files
------------

// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline definitions: stage occupancy states, default payload widths
// and the decode/execute control bundle layout.
package riscv_pipe_pkg;

    // Encoded so that the state value doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_state_t;

    // Control bundle crossing decode -> execute. Field order is fixed so every
    // stage packs and unpacks the flat vector the same way.
    typedef struct packed {
        logic [3:0] spare;
        logic       regwrite;
        logic       memwrite;
        logic       jump;
        logic [1:0] resultsrc;
        logic [2:0] memext;
        logic [4:0] alucontrol;
        logic [2:0] mulctrl;
        logic [2:0] divctrl;
        logic [1:0] funcsel;
        logic [1:0] storesrc;
        logic       oprnd1sel;
        logic       oprnd2sel;
        logic [2:0] b_condition;
    } de_ctrl_t;

    localparam int DE_CTRL_W = $bits(de_ctrl_t);
    localparam int DE_DATA_W = 416;

endpackage

// File: rtl/riscv_sat_cnt.sv
// Saturating up-counter with enable; holds at all-ones, cleared by reset only.
module riscv_sat_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_en,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    // Advance on enable unless already at the top value.
    always_comb begin
        cnt_next = cnt_reg;
        if (inc_en && (cnt_reg != {CNT_W{1'b1}})) begin
            cnt_next = cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Count register with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign cnt = cnt_reg;

endmodule

// File: rtl/riscv_de_skidreg.sv
// Decode/execute stage register with valid/ready handshake and a two-entry
// skid buffer. Upstream ready depends on state only, so execute backpressure
// never forms a combinational path into decode.
module riscv_de_skidreg
    import riscv_pipe_pkg::*;
#(
    parameter int CTRL_W   = DE_CTRL_W,
    parameter int DATA_W   = DE_DATA_W,
    parameter int CLR_DATA = 0,
    parameter int CNT_W    = 32
) (
    input  logic              i_riscv_de_clk,
    input  logic              i_riscv_de_rst,
    input  logic              i_riscv_de_flush,
    input  logic              i_riscv_de_valid_d,
    output logic              o_riscv_de_ready_d,
    input  logic [CTRL_W-1:0] i_riscv_de_ctrl_d,
    input  logic [DATA_W-1:0] i_riscv_de_data_d,
    output logic              o_riscv_de_valid_e,
    input  logic              i_riscv_de_ready_e,
    output logic [CTRL_W-1:0] o_riscv_de_ctrl_e,
    output logic [DATA_W-1:0] o_riscv_de_data_e,
    output logic [1:0]        o_riscv_de_occ,
    output logic [CNT_W-1:0]  o_riscv_de_stallcnt
);

    pipe_state_t       state_reg, state_next;
    logic [CTRL_W-1:0] main_ctrl_reg, main_ctrl_next;
    logic [DATA_W-1:0] main_data_reg, main_data_next;
    logic [CTRL_W-1:0] skid_ctrl_reg, skid_ctrl_next;
    logic [DATA_W-1:0] skid_data_reg, skid_data_next;

    // Value a data register takes when its entry is emptied.
    logic [DATA_W-1:0] main_data_bub;
    logic [DATA_W-1:0] skid_data_bub;

    logic in_fire;
    logic out_fire;
    logic stall_inc;

    generate
        if (CLR_DATA != 0) begin : g_clr_data
            assign main_data_bub = '0;
            assign skid_data_bub = '0;
        end else begin : g_hold_data
            assign main_data_bub = main_data_reg;
            assign skid_data_bub = skid_data_reg;
        end
    endgenerate

    assign in_fire   = i_riscv_de_valid_d & o_riscv_de_ready_d;
    assign out_fire  = o_riscv_de_valid_e & i_riscv_de_ready_e;
    assign stall_inc = o_riscv_de_valid_e & ~i_riscv_de_ready_e;

    // State and payload registers; reset clears everything immediately.
    always_ff @(posedge i_riscv_de_clk or posedge i_riscv_de_rst) begin
        if (i_riscv_de_rst) begin
            state_reg     <= EMPTY;
            main_ctrl_reg <= '0;
            main_data_reg <= '0;
            skid_ctrl_reg <= '0;
            skid_data_reg <= '0;
        end else begin
            state_reg     <= state_next;
            main_ctrl_reg <= main_ctrl_next;
            main_data_reg <= main_data_next;
            skid_ctrl_reg <= skid_ctrl_next;
            skid_data_reg <= skid_data_next;
        end
    end

    // Occupancy transitions; flush overrides every handshake outcome.
    always_comb begin
        state_next = state_reg;
        if (i_riscv_de_flush) begin
            state_next = EMPTY;
        end else begin
            case (state_reg)
                EMPTY: if (in_fire) state_next = ONE;
                ONE: begin
                    if (in_fire && !out_fire) begin
                        state_next = TWO;
                    end else if (!in_fire && out_fire) begin
                        state_next = EMPTY;
                    end
                end
                TWO:     if (out_fire) state_next = ONE;
                default: state_next = EMPTY;
            endcase
        end
    end

    // Payload movement: load main/skid, promote skid, bubble emptied entries.
    always_comb begin
        main_ctrl_next = main_ctrl_reg;
        main_data_next = main_data_reg;
        skid_ctrl_next = skid_ctrl_reg;
        skid_data_next = skid_data_reg;
        if (i_riscv_de_flush) begin
            main_ctrl_next = '0;
            main_data_next = main_data_bub;
            skid_ctrl_next = '0;
            skid_data_next = skid_data_bub;
        end else begin
            case (state_reg)
                EMPTY: begin
                    if (in_fire) begin
                        main_ctrl_next = i_riscv_de_ctrl_d;
                        main_data_next = i_riscv_de_data_d;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_ctrl_next = i_riscv_de_ctrl_d;
                        main_data_next = i_riscv_de_data_d;
                    end else if (in_fire) begin
                        skid_ctrl_next = i_riscv_de_ctrl_d;
                        skid_data_next = i_riscv_de_data_d;
                    end else if (out_fire) begin
                        main_ctrl_next = '0;
                        main_data_next = main_data_bub;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        main_ctrl_next = skid_ctrl_reg;
                        main_data_next = skid_data_reg;
                        skid_ctrl_next = '0;
                        skid_data_next = skid_data_bub;
                    end
                end
                default: ;
            endcase
        end
    end

    // Handshake and status outputs derived from registered state only.
    always_comb begin
        o_riscv_de_ready_d = (state_reg != TWO);
        o_riscv_de_valid_e = (state_reg != EMPTY);
        o_riscv_de_occ     = state_reg;
        o_riscv_de_ctrl_e  = main_ctrl_reg;
        o_riscv_de_data_e  = main_data_reg;
    end

    riscv_sat_cnt #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk    (i_riscv_de_clk),
        .rst    (i_riscv_de_rst),
        .inc_en (stall_inc),
        .cnt    (o_riscv_de_stallcnt)
    );

endmodule

// File: tb/tb_riscv_de_skidreg.sv
// Bench for riscv_de_skidreg: two instances share stimulus (data-hold with a
// 32-bit counter, data-clear with a 4-bit counter) and are checked every cycle
// against a FIFO-queue reference model.
module tb_riscv_de_skidreg;

    localparam int CW = 32;
    localparam int DW = 416;

    typedef struct {
        logic [CW-1:0] ctrl;
        logic [DW-1:0] data;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          valid_d;
    logic          ready_e;
    logic [CW-1:0] ctrl_d;
    logic [DW-1:0] data_d;

    logic          ready_d_a, valid_e_a, ready_d_b, valid_e_b;
    logic [CW-1:0] ctrl_e_a, ctrl_e_b;
    logic [DW-1:0] data_e_a, data_e_b;
    logic [1:0]    occ_a, occ_b;
    logic [31:0]   cnt_a;
    logic [3:0]    cnt_b;

    // Reference model state
    beat_t       q[$];     // beats held by the stage, head = presented to execute
    beat_t       src[$];   // beats decode still wants to send, head = offered
    logic [DW-1:0] last_head;
    logic [31:0] m_cnt32;
    logic [3:0]  m_cnt4;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    riscv_de_skidreg #(.CTRL_W(CW), .DATA_W(DW), .CLR_DATA(0), .CNT_W(32)) dut_a (
        .i_riscv_de_clk(clk), .i_riscv_de_rst(rst), .i_riscv_de_flush(flush),
        .i_riscv_de_valid_d(valid_d), .o_riscv_de_ready_d(ready_d_a),
        .i_riscv_de_ctrl_d(ctrl_d), .i_riscv_de_data_d(data_d),
        .o_riscv_de_valid_e(valid_e_a), .i_riscv_de_ready_e(ready_e),
        .o_riscv_de_ctrl_e(ctrl_e_a), .o_riscv_de_data_e(data_e_a),
        .o_riscv_de_occ(occ_a), .o_riscv_de_stallcnt(cnt_a)
    );

    riscv_de_skidreg #(.CTRL_W(CW), .DATA_W(DW), .CLR_DATA(1), .CNT_W(4)) dut_b (
        .i_riscv_de_clk(clk), .i_riscv_de_rst(rst), .i_riscv_de_flush(flush),
        .i_riscv_de_valid_d(valid_d), .o_riscv_de_ready_d(ready_d_b),
        .i_riscv_de_ctrl_d(ctrl_d), .i_riscv_de_data_d(data_d),
        .o_riscv_de_valid_e(valid_e_b), .i_riscv_de_ready_e(ready_e),
        .o_riscv_de_ctrl_e(ctrl_e_b), .o_riscv_de_data_e(data_e_b),
        .o_riscv_de_occ(occ_b), .o_riscv_de_stallcnt(cnt_b)
    );

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int w = 0; w < DW / 32; w++) d[w*32 +: 32] = $urandom;
        return d;
    endfunction

    function automatic beat_t mk_beat(logic [CW-1:0] c);
        beat_t b;
        b.ctrl = c;
        b.data = rand_data();
        return b;
    endfunction

    task automatic chk(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        src.delete();
        last_head = '0;
        m_cnt32   = '0;
        m_cnt4    = '0;
    endtask

    // One clock of the reference: FIFO of at most two beats.
    task automatic model_step();
        int    sz;
        bit    inf, outf;
        beat_t b;
        sz   = q.size();
        inf  = valid_d && (sz < 2);
        outf = (sz > 0) && ready_e;
        if (sz > 0 && !ready_e) begin
            if (m_cnt32 != 32'hFFFF_FFFF) m_cnt32 = m_cnt32 + 1;
            if (m_cnt4 != 4'hF) m_cnt4 = m_cnt4 + 1;
        end
        if (inf) void'(src.pop_front());
        if (flush) begin
            q.delete();
        end else begin
            if (outf) void'(q.pop_front());
            if (inf) begin
                b.ctrl = ctrl_d;
                b.data = data_d;
                q.push_back(b);
            end
        end
        if (q.size() > 0) last_head = q[0].data;
    endtask

    task automatic check_all(string tag);
        bit            has;
        logic [CW-1:0] e_ctrl;
        has    = q.size() > 0;
        e_ctrl = has ? q[0].ctrl : '0;
        chk({tag, "/valid_e_a"}, DW'(valid_e_a), DW'(has));
        chk({tag, "/valid_e_b"}, DW'(valid_e_b), DW'(has));
        chk({tag, "/ready_d_a"}, DW'(ready_d_a), DW'(q.size() < 2));
        chk({tag, "/ready_d_b"}, DW'(ready_d_b), DW'(q.size() < 2));
        chk({tag, "/occ_a"}, DW'(occ_a), DW'(q.size()));
        chk({tag, "/occ_b"}, DW'(occ_b), DW'(q.size()));
        chk({tag, "/ctrl_e_a"}, DW'(ctrl_e_a), DW'(e_ctrl));
        chk({tag, "/ctrl_e_b"}, DW'(ctrl_e_b), DW'(e_ctrl));
        chk({tag, "/data_e_a"}, data_e_a, has ? q[0].data : last_head);
        chk({tag, "/data_e_b"}, data_e_b, has ? q[0].data : '0);
        chk({tag, "/stall_a"}, DW'(cnt_a), DW'(m_cnt32));
        chk({tag, "/stall_b"}, DW'(cnt_b), DW'(m_cnt4));
    endtask

    // Drive decode from the source queue, clock once, advance model, check.
    task automatic cycle(string tag);
        valid_d = (src.size() > 0);
        ctrl_d  = valid_d ? src[0].ctrl : '0;
        data_d  = valid_d ? src[0].data : '0;
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
        $display("[%0t] %s vd=%0b re=%0b fl=%0b occ=%0d valid_e=%0b ctrl_e=%h cnt=%0d",
                 $time, tag, valid_d, ready_e, flush, occ_a, valid_e_a, ctrl_e_a, cnt_a);
    endtask

    initial begin
        logic [DW-1:0] ff_data;
        beat_t         b;

        rst = 1'b1; flush = 1'b0; valid_d = 1'b0; ready_e = 1'b0;
        ctrl_d = '0; data_d = '0;
        model_reset();
        @(posedge clk);
        #1;
        check_all("reset");
        #2 rst = 1'b0;

        // Streaming with execute always ready
        ready_e = 1'b1;
        for (int i = 1; i <= 8; i++) src.push_back(mk_beat(CW'(i)));
        for (int i = 0; i < 11; i++) cycle("stream");

        // Backpressure: 0x11 main, 0x22 skid, 0x33 held by decode
        ready_e = 1'b0;
        src.push_back(mk_beat(32'h11));
        src.push_back(mk_beat(32'h22));
        src.push_back(mk_beat(32'h33));
        for (int i = 0; i < 5; i++) cycle("bp_hold");
        ready_e = 1'b1;
        for (int i = 0; i < 5; i++) cycle("bp_release");

        // Drain to empty after 0xFF: control bubbles, data held
        b = mk_beat(32'hFF);
        ff_data = b.data;
        src.push_back(b);
        for (int i = 0; i < 3; i++) cycle("drain");
        chk("drain_ctrl", DW'(ctrl_e_a), '0);
        chk("drain_data", data_e_a, ff_data);
        chk("drain_data_clr", data_e_b, '0);

        // Flush with two entries while decode offers 0x44
        ready_e = 1'b0;
        src.push_back(mk_beat(32'hA1));
        src.push_back(mk_beat(32'hA2));
        for (int i = 0; i < 3; i++) cycle("fl_fill");
        src.push_back(mk_beat(32'h44));
        flush = 1'b1;
        cycle("flush");
        flush = 1'b0;
        src.delete();
        ready_e = 1'b1;
        for (int i = 0; i < 3; i++) cycle("post_flush");

        // Asynchronous reset with the stage full
        ready_e = 1'b0;
        src.push_back(mk_beat(32'hB1));
        src.push_back(mk_beat(32'hB2));
        for (int i = 0; i < 3; i++) cycle("rst_fill");
        rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        #1 rst = 1'b0;

        // Saturation of the 4-bit counter
        src.push_back(mk_beat(32'h5A));
        for (int i = 0; i < 21; i++) cycle("sat");
        chk("sat_cnt4", DW'(cnt_b), DW'(4'hF));
        ready_e = 1'b1;
        cycle("sat_release");

        // Randomised traffic with occasional flushes
        for (int i = 0; i < 400; i++) begin
            if (src.size() < 3 && ($urandom % 4) != 0) src.push_back(mk_beat($urandom));
            ready_e = ($urandom % 3) != 0;
            flush   = ($urandom % 40) == 0;
            cycle("rand");
            if (flush) src.delete();
        end
        flush = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
